io_tick_generator: RTL and testbench
====================================

# io_tick_generator

Parametrised multi-channel divided-timebase generator for the IO subsystem. All outputs live in the `sys_clk` domain: per-channel single-cycle tick strobes and 50%-duty square waves, with no derived clocks. Each channel's divisor and mode are written and read over the standard IO command handshake, and reads return through a single writeback port. It adds one-shot and chained (cascaded) modes and a live-counter readback.

## Interface
Parameters:
- `DATABITWIDTH`, 16: command/writeback data width.
- `CHANNELCOUNT`, 4: number of tick channels, 1..16.
- `DIVBITWIDTH`, 14: divisor/counter width. Must satisfy DIVBITWIDTH <= DATABITWIDTH-2.

Ports:
- `sys_clk`  in  1  sole clock, rising edge.
- `sync_rst`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  global enable. When low, all state holds.
- `CommandACK`  in  1  command valid.
- `CommandREQ`  out  1  command ready. A transfer occurs on ACK&&REQ&&clk_en.
- `MinorOpcodeIn`  in  4  bit2: 1=store (write config), 0=load.
- `CommandAddressIn_Offest`  in  DATABITWIDTH  bits [CW:1] select the channel, where CW=max(1,clog2(CHANNELCOUNT)). Bit0 selects the load source: 0=config, 1=live counter.
- `CommandDataIn`  in  DATABITWIDTH  store word: [DATABITWIDTH-1:DATABITWIDTH-2]=mode, [DIVBITWIDTH-1:0]=divisor.
- `CommandDestReg`  in  4  destination register for loads.
- `WritebackACK`  out  1  response valid.
- `WritebackREQ`  in  1  response ready.
- `WritebackDestReg`  out  4  echoed destination register.
- `WritebackDataOut`  out  DATABITWIDTH  load result.
- `TickOut`  out  CHANNELCOUNT  registered one-cycle strobe per channel.
- `SquareOut`  out  CHANNELCOUNT  registered; toggles on each tick of its channel.

## Operation
- Per-channel state: mode[1:0], divisor, counter, tick register, square register.
- Modes:
  - 00: disabled. The counter holds and no ticks are produced.
  - 01: free-run.
  - 10: one-shot.
  - 11: chained. The counter decrements only in cycles where `TickOut[i-1]` is 1. Channel 0 in mode 11 behaves as free-run.
- Count rule (free-run/one-shot, or chained when upstream ticks): if counter==0, reload it with the divisor and set the tick for the next cycle. Otherwise decrement.
- One-shot: on its first terminal count, emit the tick and write mode to 00. Mode 00 is visible on readback.
- Store accepted:
  - The addressed channel's mode, divisor and counter are all loaded from the data (counter = divisor), and the square output is cleared.
  - Any terminal count of that channel in the same cycle is suppressed, because the store wins.
  - Unused data bits are ignored.
- Load accepted:
  - The result is captured into a one-entry response register in the accept cycle.
  - Bit0=0 returns {mode, zero pad, divisor}. Bit0=1 returns the zero-extended counter value.
- Out-of-range channel (index >= CHANNELCOUNT): the store is ignored and the load returns 0. Both are still handshaken.
- `CommandREQ` = clk_en && (MinorOpcodeIn[2] ? 1 : (~WritebackACK || WritebackREQ)).
  - Stores are never blocked.
  - A load may be accepted in the same cycle the pending response drains.
- `WritebackACK` stays high until WritebackREQ&&clk_en. Data and dest are stable while it is high.
- clk_en low:
  - Counters, the response register and the square outputs hold.
  - `TickOut` is forced to 0.
  - No transfers occur.
- Reset values: all mode=00, divisor=0, counter=0, TickOut=0, SquareOut=0, WritebackACK=0, WritebackDataOut=0, WritebackDestReg=0. Reset mid-operation discards a pending response and stops all channels in the next cycle.

## Timing
- Store accepted at cycle t with divisor D and mode 01: the counter equals D at t+1. The first TickOut is at t+D+2, then every D+1 cycles. SquareOut period is 2(D+1).
- D=0 gives TickOut high every cycle from t+2 and SquareOut toggling every cycle.
- Chained channel i with divisor D ticks once per D+1 upstream ticks, one cycle after the qualifying upstream tick.
- A one-shot with divisor D ticks exactly once, at t+D+2. Mode reads 00 from t+D+2.
- Load accepted at t: WritebackACK=1 at t+1. Back-to-back loads with WritebackREQ held high give one response per cycle.
- The counter value returned by a load is the value present in the accept cycle.

## Test plan
- Reset, then store ch0 mode01 D=3 at t: TickOut[0] pulses at t+5, t+9, t+13. SquareOut[0] is high over [t+5,t+9).
- ch0 mode01 D=1, ch1 mode11 D=2: TickOut[1] fires once every 3 ch0 ticks, i.e. every 6 cycles, one cycle after the ch0 tick.
- ch2 mode10 D=4: a single tick at t+6 and none thereafter. A subsequent config load returns mode=00, divisor=4.
- Hold WritebackREQ=0, issue a load: the response holds, CommandREQ=0 for a further load, and CommandREQ=1 for a store. Then raise WritebackREQ: the drain and a new accept occur in the same cycle.
- Drop clk_en for 5 cycles mid-count: no ticks during those cycles and subsequent ticks shift by exactly 5 cycles. Assert sync_rst mid-count: all outputs are 0 next cycle.
- Store to channel 5 with CHANNELCOUNT=4: no state change. A load of channel 5 returns 0 with the correct WritebackDestReg.

Source files
------------

// File: rtl/io_tick_generator.sv
// Multi-channel divided-timebase generator: per-channel tick strobes and square waves in the sys_clk domain,
// configured and read back over the IO command/writeback handshake.
module io_tick_generator #(
  parameter int DATABITWIDTH = 16,
  parameter int CHANNELCOUNT = 4,
  parameter int DIVBITWIDTH  = 14
) (
  input  logic                    sys_clk,
  input  logic                    sync_rst,
  input  logic                    clk_en,
  input  logic                    CommandACK,
  output logic                    CommandREQ,
  input  logic [3:0]              MinorOpcodeIn,
  input  logic [DATABITWIDTH-1:0] CommandAddressIn_Offest,
  input  logic [DATABITWIDTH-1:0] CommandDataIn,
  input  logic [3:0]              CommandDestReg,
  output logic                    WritebackACK,
  input  logic                    WritebackREQ,
  output logic [3:0]              WritebackDestReg,
  output logic [DATABITWIDTH-1:0] WritebackDataOut,
  output logic [CHANNELCOUNT-1:0] TickOut,
  output logic [CHANNELCOUNT-1:0] SquareOut
);
  localparam int CW = (CHANNELCOUNT > 1) ? $clog2(CHANNELCOUNT) : 1;
  localparam logic [DATABITWIDTH-2:0] chanLimit = (DATABITWIDTH-1)'(CHANNELCOUNT);

  logic [1:0]             modeReg [CHANNELCOUNT];
  logic [DIVBITWIDTH-1:0] divReg  [CHANNELCOUNT];
  logic [DIVBITWIDTH-1:0] cntReg  [CHANNELCOUNT];
  logic [CHANNELCOUNT-1:0] tickReg, squareReg, upTick, countEn, storeHit;

  logic                    isStore, cmdFire, storeFire, loadFire, inRange;
  logic [CW-1:0]           chanSel;
  logic [1:0]              storeMode;
  logic [DIVBITWIDTH-1:0]  storeDiv;
  logic [DATABITWIDTH-1:0] loadData;
  logic                    unusedOk;

  assign isStore    = MinorOpcodeIn[2];
  assign CommandREQ = clk_en && (isStore || !WritebackACK || WritebackREQ);
  assign cmdFire    = CommandACK && CommandREQ;
  assign storeFire  = cmdFire && isStore;
  assign loadFire   = cmdFire && !isStore;
  // The whole upper address is range-checked so aliases above the select bits never hit a real channel.
  assign inRange    = CommandAddressIn_Offest[DATABITWIDTH-1:1] < chanLimit;
  assign chanSel    = CommandAddressIn_Offest[CW:1];
  assign storeMode  = CommandDataIn[DATABITWIDTH-1 -: 2];
  assign storeDiv   = CommandDataIn[DIVBITWIDTH-1:0];
  assign unusedOk   = ^{MinorOpcodeIn[3], MinorOpcodeIn[1:0], CommandDataIn};

  assign TickOut   = tickReg & {CHANNELCOUNT{clk_en}};
  assign SquareOut = squareReg;

  always_comb begin
    upTick   = '0;
    countEn  = '0;
    storeHit = '0;
    loadData = '0;
    upTick[0] = 1'b1;
    for (int i = 1; i < CHANNELCOUNT; i++) begin
      upTick[i] = tickReg[i-1];
    end
    for (int i = 0; i < CHANNELCOUNT; i++) begin
      countEn[i]  = (modeReg[i] == 2'b01) || (modeReg[i] == 2'b10) ||
                    ((modeReg[i] == 2'b11) && upTick[i]);
      storeHit[i] = storeFire && inRange && (chanSel == CW'(i));
      if (inRange && (chanSel == CW'(i))) begin
        if (CommandAddressIn_Offest[0]) begin
          loadData[DIVBITWIDTH-1:0] = cntReg[i];
        end else begin
          loadData[DATABITWIDTH-1 -: 2]  = modeReg[i];
          loadData[DIVBITWIDTH-1:0]      = divReg[i];
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      for (int i = 0; i < CHANNELCOUNT; i++) begin
        modeReg[i] <= 2'b00;
        divReg[i]  <= '0;
        cntReg[i]  <= '0;
      end
      tickReg          <= '0;
      squareReg        <= '0;
      WritebackACK     <= 1'b0;
      WritebackDataOut <= '0;
      WritebackDestReg <= '0;
    end else if (clk_en) begin
      for (int i = 0; i < CHANNELCOUNT; i++) begin
        tickReg[i] <= 1'b0;
        if (storeHit[i]) begin
          modeReg[i]   <= storeMode;
          divReg[i]    <= storeDiv;
          cntReg[i]    <= storeDiv;
          squareReg[i] <= 1'b0;
        end else if (countEn[i]) begin
          if (cntReg[i] == '0) begin
            cntReg[i]    <= divReg[i];
            tickReg[i]   <= 1'b1;
            squareReg[i] <= ~squareReg[i];
            if (modeReg[i] == 2'b10) begin
              modeReg[i] <= 2'b00;
            end
          end else begin
            cntReg[i] <= cntReg[i] - DIVBITWIDTH'(1);
          end
        end
      end
      if (loadFire) begin
        WritebackACK     <= 1'b1;
        WritebackDataOut <= loadData;
        WritebackDestReg <= CommandDestReg;
      end else if (WritebackACK && WritebackREQ) begin
        WritebackACK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_tick_generator.sv
// Directed bench for io_tick_generator: a per-cycle vector table for free-run timing and loads,
// plus hand sequences for chaining, one-shot, handshake back-pressure, clk_en, reset and range checks.
module tb_io_tick_generator;
  logic        sys_clk = 1'b0;
  logic        sync_rst = 1'b0;
  logic        clk_en = 1'b1;
  logic        CommandACK = 1'b0;
  logic        CommandREQ;
  logic [3:0]  MinorOpcodeIn = 4'h0;
  logic [15:0] CommandAddressIn_Offest = 16'h0;
  logic [15:0] CommandDataIn = 16'h0;
  logic [3:0]  CommandDestReg = 4'h0;
  logic        WritebackACK;
  logic        WritebackREQ = 1'b1;
  logic [3:0]  WritebackDestReg;
  logic [15:0] WritebackDataOut;
  logic [3:0]  TickOut;
  logic [3:0]  SquareOut;

  int checks = 0;
  int errors = 0;

  io_tick_generator #(.DATABITWIDTH(16), .CHANNELCOUNT(4), .DIVBITWIDTH(14)) dut (
    .sys_clk(sys_clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .CommandACK(CommandACK), .CommandREQ(CommandREQ), .MinorOpcodeIn(MinorOpcodeIn),
    .CommandAddressIn_Offest(CommandAddressIn_Offest), .CommandDataIn(CommandDataIn),
    .CommandDestReg(CommandDestReg), .WritebackACK(WritebackACK), .WritebackREQ(WritebackREQ),
    .WritebackDestReg(WritebackDestReg), .WritebackDataOut(WritebackDataOut),
    .TickOut(TickOut), .SquareOut(SquareOut)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        ack;
    logic [3:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  dest;
    logic [3:0]  expTick;
    logic [3:0]  expSq;
    logic        expWbAck;
    logic [15:0] expWbData;
    logic [3:0]  expWbDest;
  } vec_t;

  vec_t vec [13];

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic doReset();
    sync_rst = 1'b1;
    CommandACK = 1'b0;
    clk_en = 1'b1;
    WritebackREQ = 1'b1;
    step();
    step();
    sync_rst = 1'b0;
  endtask

  task automatic doStore(input int ch, input logic [1:0] mode, input logic [13:0] div);
    CommandACK = 1'b1;
    MinorOpcodeIn = 4'h4;
    CommandAddressIn_Offest = 16'(ch * 2);
    CommandDataIn = {mode, div};
    step();
    CommandACK = 1'b0;
    MinorOpcodeIn = 4'h0;
  endtask

  task automatic doLoad(input string name, input logic [15:0] addr, input logic [3:0] dest,
                        input logic [15:0] expData);
    int n;
    CommandACK = 1'b1;
    MinorOpcodeIn = 4'h0;
    CommandAddressIn_Offest = addr;
    CommandDestReg = dest;
    #1;
    n = 0;
    while (!CommandREQ && n < 20) begin
      step();
      n++;
    end
    check({name, "_req_wait"}, (n < 20), 1);
    step();
    CommandACK = 1'b0;
    check({name, "_ack"}, WritebackACK, 1);
    check({name, "_data"}, WritebackDataOut, expData);
    check({name, "_dest"}, WritebackDestReg, dest);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    //        ack  op    addr     data     dest  tick  sq    wb    wbData   wbDest
    vec[0]  = '{1'b1, 4'h4, 16'h0000, 16'h4003, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 4'h0};
    vec[1]  = '{1'b1, 4'h0, 16'h0001, 16'h0000, 4'h3, 4'h0, 4'h0, 1'b1, 16'h0003, 4'h3};
    vec[2]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 4'h0};
    vec[3]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 4'h0};
    vec[4]  = '{1'b1, 4'h0, 16'h0001, 16'h0000, 4'h5, 4'h1, 4'h1, 1'b1, 16'h0000, 4'h5};
    vec[5]  = '{1'b1, 4'h0, 16'h0000, 16'h0000, 4'h6, 4'h0, 4'h1, 1'b1, 16'h4003, 4'h6};
    vec[6]  = '{1'b1, 4'h0, 16'h0001, 16'h0000, 4'h7, 4'h0, 4'h1, 1'b1, 16'h0002, 4'h7};
    vec[7]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h1, 1'b0, 16'h0000, 4'h0};
    vec[8]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h1, 4'h0, 1'b0, 16'h0000, 4'h0};
    vec[9]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 4'h0};
    vec[10] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 4'h0};
    vec[11] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 4'h0};
    vec[12] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h1, 4'h1, 1'b0, 16'h0000, 4'h0};

    // Reset state
    doReset();
    check("rst_tick", TickOut, 4'h0);
    check("rst_sq", SquareOut, 4'h0);
    check("rst_wbAck", WritebackACK, 0);
    check("rst_wbData", WritebackDataOut, 16'h0);
    check("rst_wbDest", WritebackDestReg, 4'h0);

    // Free-run ch0 D=3 with interleaved loads, one row per cycle
    for (int r = 0; r < 13; r++) begin
      CommandACK = vec[r].ack;
      MinorOpcodeIn = vec[r].op;
      CommandAddressIn_Offest = vec[r].addr;
      CommandDataIn = vec[r].data;
      CommandDestReg = vec[r].dest;
      step();
      check($sformatf("vec%0d_tick", r), TickOut, vec[r].expTick);
      check($sformatf("vec%0d_sq", r), SquareOut, vec[r].expSq);
      check($sformatf("vec%0d_wbAck", r), WritebackACK, vec[r].expWbAck);
      if (vec[r].expWbAck) begin
        check($sformatf("vec%0d_wbData", r), WritebackDataOut, vec[r].expWbData);
        check($sformatf("vec%0d_wbDest", r), WritebackDestReg, vec[r].expWbDest);
      end
    end
    CommandACK = 1'b0;

    // Chained: ch0 free-run D=1, ch1 chained D=2
    doReset();
    doStore(0, 2'b01, 14'd1);
    doStore(1, 2'b11, 14'd2);
    for (int c = 2; c <= 26; c++) begin
      check($sformatf("chain_tick0_c%0d", c), TickOut[0], (c >= 3) && ((c - 3) % 2 == 0));
      check($sformatf("chain_tick1_c%0d", c), TickOut[1], (c >= 8) && ((c - 8) % 6 == 0));
      step();
    end

    // One-shot ch2 D=4
    doReset();
    doStore(2, 2'b10, 14'd4);
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("oneshot_tick2_c%0d", c), TickOut[2], (c == 6));
      step();
    end
    doLoad("oneshot_cfg", 16'd4, 4'd2, 16'h0004);
    doLoad("oneshot_cnt", 16'd5, 4'd3, 16'h0004);

    // Writeback back-pressure
    doReset();
    doStore(0, 2'b01, 14'd3);
    WritebackREQ = 1'b0;
    doLoad("hs_first", 16'd0, 4'd1, 16'h4003);
    CommandACK = 1'b1;
    MinorOpcodeIn = 4'h0;
    CommandAddressIn_Offest = 16'd6;
    CommandDestReg = 4'd9;
    #1;
    check("hs_load_blocked", CommandREQ, 0);
    step();
    check("hs_hold_ack", WritebackACK, 1);
    check("hs_hold_data", WritebackDataOut, 16'h4003);
    check("hs_hold_dest", WritebackDestReg, 4'd1);
    MinorOpcodeIn = 4'h4;
    CommandDataIn = 16'h0007;
    #1;
    check("hs_store_open", CommandREQ, 1);
    step();
    MinorOpcodeIn = 4'h0;
    #1;
    check("hs_load_blocked2", CommandREQ, 0);
    WritebackREQ = 1'b1;
    #1;
    check("hs_drain_req", CommandREQ, 1);
    step();
    CommandACK = 1'b0;
    check("hs_new_ack", WritebackACK, 1);
    check("hs_new_data", WritebackDataOut, 16'h0007);
    check("hs_new_dest", WritebackDestReg, 4'd9);
    step();
    check("hs_drained", WritebackACK, 0);

    // clk_en gap of 5 cycles, then reset mid-count
    doReset();
    doStore(0, 2'b01, 14'd3);
    for (int c = 1; c <= 19; c++) begin
      clk_en = !(c >= 6 && c <= 10);
      #1;
      check($sformatf("en_tick_c%0d", c), TickOut[0], (c == 5) || (c == 14) || (c == 18));
      check($sformatf("en_sq_c%0d", c), SquareOut[0], ((c >= 5) && (c < 14)) || (c >= 18));
      if (c == 8) check("en_req_low", CommandREQ, 0);
      step();
    end
    clk_en = 1'b1;
    WritebackREQ = 1'b0;
    doLoad("pre_rst_load", 16'd0, 4'd4, 16'h4003);
    check("pre_rst_sq", SquareOut[0], 1);
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    WritebackREQ = 1'b1;
    check("mid_rst_tick", TickOut, 4'h0);
    check("mid_rst_sq", SquareOut, 4'h0);
    check("mid_rst_wbAck", WritebackACK, 0);
    check("mid_rst_wbData", WritebackDataOut, 16'h0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("post_rst_tick_c%0d", c), TickOut, 4'h0);
      step();
    end

    // Out-of-range channel 5, then D=0 boundary on ch3
    doReset();
    CommandACK = 1'b1;
    MinorOpcodeIn = 4'h4;
    CommandAddressIn_Offest = 16'd10;
    CommandDataIn = 16'h4000;
    step();
    CommandACK = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("oor_tick_c%0d", c), TickOut, 4'h0);
      step();
    end
    doLoad("oor_ch1_cfg", 16'd2, 4'd1, 16'h0000);
    doLoad("oor_ch5_cfg", 16'd10, 4'hA, 16'h0000);
    doLoad("oor_ch5_cnt", 16'd11, 4'hB, 16'h0000);
    doStore(3, 2'b01, 14'd0);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("d0_tick3_c%0d", c), TickOut[3], (c >= 2));
      check($sformatf("d0_sq3_c%0d", c), SquareOut[3], (c >= 2) && (c % 2 == 0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
